dram_user_master: RTL and testbench
===================================

DRAM_USER_MASTER -- requirements
Module: dram_user_master

Interface
REQ-001 SHALL have parameters: NUMBER_OF_COLUMNS=8 (columns per row); NUMBER_OF_ROWS=128 (rows per bank); NUMBER_OF_BANKS=8 (bank count); U_DATA_WIDTH=2 (user data bits); DRAM_DATA_WIDTH=2 (DRAM word bits); QUEUE_DEPTH=4 (request slots, power of 2); TIMEOUT_CYCLES=64 (watchdog limit).
REQ-002 SHALL have port u_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port u_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, host request strobe.
REQ-005 SHALL have port req_ready, output, 1, queue can accept a request.
REQ-006 SHALL have port req_cmd, input, 1, 0=read, 1=write.
REQ-007 SHALL have port req_addr, input, U_ADDR_WIDTH, <bank_id; row; col>, with col in the LSBs.
REQ-008 SHALL have port req_wdata, input, U_DATA_WIDTH, write data.
REQ-009 SHALL have port resp_valid, output, 1, one-cycle read-data pulse.
REQ-010 SHALL have port resp_data, output, U_DATA_WIDTH, read data.
REQ-011 SHALL have port resp_addr, output, U_ADDR_WIDTH, address of the returned read.
REQ-012 SHALL have ports u_en, u_addr, u_data_i and u_cmd as outputs, driving the controller user port.
REQ-013 SHALL have ports u_data_o, u_data_valid, u_cmd_ack and u_busy as inputs, from the controller user port.
REQ-014 SHALL have port idle, output, 1, set when the queue is empty and the FSM is in IDLE.

Function
REQ-015 SHALL derive the address width as U_ADDR_WIDTH = clog2(BANKS) + clog2(ROWS) + clog2(COLUMNS/DRAM_DATA_WIDTH), which is 12 at the defaults.
REQ-016 SHALL push {cmd, addr, wdata} into the FIFO when req_valid && req_ready; req_ready = !full.
REQ-017 SHALL, when a push and a pop occur in the same cycle, leave the count unchanged; a push while full is impossible by construction.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE and WAIT_DATA.
REQ-019 SHALL, in IDLE with the FIFO non-empty and u_busy==0, move to ISSUE on the next edge and load u_addr/u_cmd/u_data_i from the FIFO head.
REQ-020 SHALL, in ISSUE, hold u_en=1 with u_addr/u_cmd/u_data_i stable until u_cmd_ack==1 is sampled, then pop the FIFO in that same cycle.
REQ-021 SHALL, on ack of a write, go to WAIT_DONE; WAIT_DONE returns to IDLE when u_busy==0.
REQ-022 SHALL, on ack of a read, go to WAIT_DATA; on u_data_valid==1 it registers u_data_o into resp_data, sets resp_addr and pulses resp_valid for exactly 1 cycle (latency 1 from u_data_valid), then returns to IDLE.
REQ-023 SHALL drive u_en=1 in ISSUE, WAIT_DONE and WAIT_DATA, and 0 in IDLE.
REQ-024 SHALL keep at most one controller transaction outstanding; back-to-back issue is possible no sooner than the cycle after the return to IDLE.
REQ-025 SHALL ignore u_data_valid outside WAIT_DATA and u_cmd_ack outside ISSUE.

Reset
REQ-026 SHALL, on u_rst_n low at any time, including mid-transaction, asynchronously force: FSM=IDLE, FIFO empty, req_ready=1, u_en=0, u_addr=0, u_data_i=0, u_cmd=0, resp_valid=0, resp_data=0, resp_addr=0, idle=1, err_timeout=0.
REQ-027 SHALL leave an interrupted transaction dropped after reset, with no response pulse.

Configuration
REQ-028 SHALL, with macro DRAM_USER_MASTER_TIMEOUT_EN defined, add output err_timeout (1 bit, sticky until reset) and a watchdog counter cleared on each state entry; if the FSM stays in ISSUE, WAIT_DONE or WAIT_DATA for TIMEOUT_CYCLES cycles, err_timeout is set, the current entry is discarded (popped if still unacked), no resp_valid is issued, and the FSM returns to IDLE.
REQ-029 SHALL, without the macro, have no err_timeout port and no counter, and wait indefinitely.

Structure
REQ-030 SHALL place the derived width constants, the state enum and the command encodings (CMD_READ=0, CMD_WRITE=1) in package dram_user_pkg.
REQ-031 SHALL implement the queue as sub-module dram_req_fifo, a parameterised synchronous FIFO with full/empty flags and wrap-around pointers.

Verification
REQ-032 SHALL cover a single write: push cmd=1 addr=0x0A5 data=2 -> u_addr=0x0A5 and u_cmd=1 held until ack, then idle=1 after u_busy falls.
REQ-033 SHALL cover a read-after-write: write data=3 to addr=0x7FF, then read 0x7FF -> one resp_valid pulse with resp_data=3 and resp_addr=0x7FF.
REQ-034 SHALL cover fill to full: hold u_busy=1 and push 4 requests -> req_ready=0 after the 4th; release busy -> all 4 issue in order and req_ready returns to 1.
REQ-035 SHALL cover a simultaneous push and pop at count=2 -> count stays 2 and order is preserved.
REQ-036 SHALL cover reset asserted in WAIT_DATA -> all outputs at reset values immediately, with no resp_valid afterwards.
REQ-037 SHALL cover, with DRAM_USER_MASTER_TIMEOUT_EN, u_cmd_ack never asserted -> err_timeout=1 after 64 cycles in ISSUE, the FSM back in IDLE, and the next request issued.

Source files
------------

// File: rtl/dram_user_pkg.sv
// Shared constants, command encodings and FSM state type for the DRAM user-port master.
package dram_user_pkg;

    localparam int unsigned DEF_COLUMNS    = 8;
    localparam int unsigned DEF_ROWS       = 128;
    localparam int unsigned DEF_BANKS      = 8;
    localparam int unsigned DEF_DRAM_WIDTH = 2;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone,
        StWaitData
    } state_e;

    // Column field addresses DRAM words, not individual columns.
    function automatic int unsigned calc_addr_width(input int unsigned banks,
                                                    input int unsigned rows,
                                                    input int unsigned cols,
                                                    input int unsigned dram_width);
        return $clog2(banks) + $clog2(rows) + $clog2(cols / dram_width);
    endfunction

    localparam int unsigned DEF_U_ADDR_WIDTH =
        calc_addr_width(DEF_BANKS, DEF_ROWS, DEF_COLUMNS, DEF_DRAM_WIDTH);

endpackage

// File: rtl/dram_req_fifo.sv
// Synchronous request FIFO with full/empty flags; Depth must be a power of two (>= 2).
module dram_req_fifo #(
    parameter int unsigned Width = 15,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count_q == (PtrW + 1)'(Depth));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/dram_user_master.sv
// Queues host read/write requests and issues them one at a time to a DRAM controller user port.
// Optional watchdog with err_timeout output: define DRAM_USER_MASTER_TIMEOUT_EN.
module dram_user_master
    import dram_user_pkg::*;
#(
    parameter int unsigned NUMBER_OF_COLUMNS = DEF_COLUMNS,
    parameter int unsigned NUMBER_OF_ROWS    = DEF_ROWS,
    parameter int unsigned NUMBER_OF_BANKS   = DEF_BANKS,
    parameter int unsigned U_DATA_WIDTH      = 2,
    parameter int unsigned DRAM_DATA_WIDTH   = DEF_DRAM_WIDTH,
    parameter int unsigned QUEUE_DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYCLES    = 64,
    localparam int unsigned U_ADDR_WIDTH =
        calc_addr_width(NUMBER_OF_BANKS, NUMBER_OF_ROWS, NUMBER_OF_COLUMNS, DRAM_DATA_WIDTH)
) (
    input  logic                    u_clk,
    input  logic                    u_rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_cmd,
    input  logic [U_ADDR_WIDTH-1:0] req_addr,
    input  logic [U_DATA_WIDTH-1:0] req_wdata,
    output logic                    resp_valid,
    output logic [U_DATA_WIDTH-1:0] resp_data,
    output logic [U_ADDR_WIDTH-1:0] resp_addr,
    output logic                    u_en,
    output logic [U_ADDR_WIDTH-1:0] u_addr,
    output logic [U_DATA_WIDTH-1:0] u_data_i,
    output logic                    u_cmd,
    input  logic [U_DATA_WIDTH-1:0] u_data_o,
    input  logic                    u_data_valid,
    input  logic                    u_cmd_ack,
    input  logic                    u_busy,
`ifdef DRAM_USER_MASTER_TIMEOUT_EN
    output logic                    err_timeout,
`endif
    output logic                    idle
);

    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    typedef struct packed {
        logic                    cmd;
        logic [U_ADDR_WIDTH-1:0] addr;
        logic [U_DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t   push_entry, head;
    logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
    state_e state_q, state_d;
    logic   load_cmd, resp_capture;

    logic [U_ADDR_WIDTH-1:0] u_addr_q, resp_addr_q;
    logic [U_DATA_WIDTH-1:0] u_data_q, resp_data_q;
    logic                    u_cmd_q, resp_valid_q;

    assign push_entry = '{cmd: req_cmd, addr: req_addr, wdata: req_wdata};
    assign fifo_push  = req_valid && req_ready;
    assign req_ready  = !fifo_full;

    dram_req_fifo #(
        .Width ($bits(req_t)),
        .Depth (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (u_clk),
        .rst_n (u_rst_n),
        .push  (fifo_push),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef DRAM_USER_MASTER_TIMEOUT_EN
    localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WdW-1:0] wd_cnt_q;
    logic           timeout_hit;
    logic           err_timeout_q;
`endif

    always_comb begin
        state_d      = state_q;
        fifo_pop     = 1'b0;
        load_cmd     = 1'b0;
        resp_capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !u_busy) begin
                    state_d  = StIssue;
                    load_cmd = 1'b1;
                end
            end
            StIssue: begin
                if (u_cmd_ack) begin
                    fifo_pop = 1'b1;
                    state_d  = (u_cmd_q == CMD_WRITE) ? StWaitDone : StWaitData;
                end
            end
            StWaitDone: begin
                if (!u_busy) state_d = StIdle;
            end
            StWaitData: begin
                if (u_data_valid) begin
                    resp_capture = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef DRAM_USER_MASTER_TIMEOUT_EN
        // Normal progress on the last allowed cycle wins over the watchdog.
        timeout_hit = 1'b0;
        if (state_q != StIdle && state_d == state_q &&
            wd_cnt_q == WdW'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            state_d     = StIdle;
            if (state_q == StIssue) fifo_pop = 1'b1;
        end
`endif
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            state_q      <= StIdle;
            u_addr_q     <= '0;
            u_data_q     <= '0;
            u_cmd_q      <= CMD_READ;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_capture;
            if (load_cmd) begin
                u_addr_q <= head.addr;
                u_data_q <= head.wdata;
                u_cmd_q  <= head.cmd;
            end
            if (resp_capture) begin
                resp_data_q <= u_data_o;
                resp_addr_q <= u_addr_q;
            end
        end
    end

`ifdef DRAM_USER_MASTER_TIMEOUT_EN
    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            wd_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (state_d != state_q)     wd_cnt_q <= '0;
            else if (state_q != StIdle) wd_cnt_q <= wd_cnt_q + WdW'(1);
            if (timeout_hit) err_timeout_q <= 1'b1;
        end
    end

    assign err_timeout = err_timeout_q;
`endif

    assign u_en       = (state_q != StIdle);
    assign u_addr     = u_addr_q;
    assign u_data_i   = u_data_q;
    assign u_cmd      = u_cmd_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_addr  = resp_addr_q;
    assign idle       = fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_dram_user_master.sv
// Directed bench for dram_user_master: vector table plus hand-written corner-case sequences.
module tb_dram_user_master;
    import dram_user_pkg::*;

    localparam int AW = 12;
    localparam int DW = 2;

    logic          u_clk, u_rst_n;
    logic          req_valid, req_ready, req_cmd;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] resp_addr;
    logic          u_en, u_cmd;
    logic [AW-1:0] u_addr;
    logic [DW-1:0] u_data_i, u_data_o;
    logic          u_data_valid, u_cmd_ack, u_busy, idle;
`ifdef DRAM_USER_MASTER_TIMEOUT_EN
    logic          err_timeout;
`endif

    dram_user_master dut (
        .u_clk        (u_clk),
        .u_rst_n      (u_rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_addr    (resp_addr),
        .u_en         (u_en),
        .u_addr       (u_addr),
        .u_data_i     (u_data_i),
        .u_cmd        (u_cmd),
        .u_data_o     (u_data_o),
        .u_data_valid (u_data_valid),
        .u_cmd_ack    (u_cmd_ack),
        .u_busy       (u_busy),
`ifdef DRAM_USER_MASTER_TIMEOUT_EN
        .err_timeout  (err_timeout),
`endif
        .idle         (idle)
    );

    initial u_clk = 1'b0;
    always #5 u_clk = ~u_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [4096];

    typedef struct {
        logic          cmd;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_resp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 1);
        check({tag, "_u_en"}, 32'(u_en), 0);
        check({tag, "_u_addr"}, 32'(u_addr), 0);
        check({tag, "_u_data_i"}, 32'(u_data_i), 0);
        check({tag, "_u_cmd"}, 32'(u_cmd), 0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 0);
        check({tag, "_resp_data"}, 32'(resp_data), 0);
        check({tag, "_resp_addr"}, 32'(resp_addr), 0);
        check({tag, "_idle"}, 32'(idle), 1);
`ifdef DRAM_USER_MASTER_TIMEOUT_EN
        check({tag, "_err_timeout"}, 32'(err_timeout), 0);
`endif
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push(input logic cmd, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge u_clk);
        check("push_ready", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge u_clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_en();
        for (int i = 0; i < 40 && !u_en; i++) @(negedge u_clk);
        check("issue_seen", 32'(u_en), 1);
    endtask

    // Acts as the controller for one transaction, checking the command and any response.
    task automatic serve(input logic exp_cmd, input logic [AW-1:0] exp_addr,
                         input logic [DW-1:0] exp_wdata, input logic [DW-1:0] exp_resp);
        wait_en();
        check("issue_cmd", 32'(u_cmd), 32'(exp_cmd));
        check("issue_addr", 32'(u_addr), 32'(exp_addr));
        if (exp_cmd == CMD_WRITE) check("issue_wdata", 32'(u_data_i), 32'(exp_wdata));
        @(negedge u_clk);
        check("hold_en", 32'(u_en), 1);
        check("hold_addr", 32'(u_addr), 32'(exp_addr));
        check("hold_cmd", 32'(u_cmd), 32'(exp_cmd));
        u_cmd_ack = 1'b1;
        u_busy    = 1'b1;
        if (u_cmd == CMD_WRITE) mem[u_addr] = u_data_i;
        @(negedge u_clk);
        u_cmd_ack = 1'b0;
        if (exp_cmd == CMD_WRITE) begin
            @(negedge u_clk);
            u_busy = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge u_clk);
                if (!u_en) break;
            end
            check("write_done", 32'(u_en), 0);
        end else begin
            u_busy       = 1'b0;
            u_data_o     = mem[u_addr];
            u_data_valid = 1'b1;
            check("resp_early", 32'(resp_valid), 0);
            @(negedge u_clk);
            u_data_valid = 1'b0;
            u_data_o     = '0;
            check("resp_valid", 32'(resp_valid), 1);
            check("resp_data", 32'(resp_data), 32'(exp_resp));
            check("resp_addr", 32'(resp_addr), 32'(exp_addr));
            @(negedge u_clk);
            check("resp_pulse", 32'(resp_valid), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int cycles;

        vecs[0] = '{1'b1, 12'h0A5, 2'd2, 2'd0};
        vecs[1] = '{1'b1, 12'h7FF, 2'd3, 2'd0};
        vecs[2] = '{1'b0, 12'h7FF, 2'd0, 2'd3};
        vecs[3] = '{1'b1, 12'h000, 2'd1, 2'd0};
        vecs[4] = '{1'b0, 12'h000, 2'd0, 2'd1};
        vecs[5] = '{1'b0, 12'h0A5, 2'd0, 2'd2};
        vecs[6] = '{1'b1, 12'h0A5, 2'd0, 2'd0};
        vecs[7] = '{1'b0, 12'h0A5, 2'd0, 2'd0};
        vecs[8] = '{1'b0, 12'h7FF, 2'd0, 2'd3};
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        u_rst_n      = 1'b0;
        req_valid    = 1'b0;
        req_cmd      = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        u_data_o     = '0;
        u_data_valid = 1'b0;
        u_cmd_ack    = 1'b0;
        u_busy       = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge u_clk);
        @(negedge u_clk);
        u_rst_n = 1'b1;
        @(negedge u_clk);

        // Table: single writes, reads, read-after-write.
        for (int v = 0; v < 9; v++) begin
            push(vecs[v].cmd, vecs[v].addr, vecs[v].wdata);
            serve(vecs[v].cmd, vecs[v].addr, vecs[v].wdata, vecs[v].exp_resp);
            check("vec_idle", 32'(idle), 1);
        end

        // Fill to full while the controller is busy.
        u_busy = 1'b1;
        for (int k = 0; k < 4; k++) push(1'b1, 12'h100 + 12'(k), 2'(k));
        check("full_ready", 32'(req_ready), 0);
        check("full_no_issue", 32'(u_en), 0);
        check("full_not_idle", 32'(idle), 0);
        u_busy = 1'b0;
        for (int k = 0; k < 4; k++) serve(1'b1, 12'h100 + 12'(k), 2'(k), 2'd0);
        check("drain_ready", 32'(req_ready), 1);
        check("drain_idle", 32'(idle), 1);

        // Simultaneous push and pop with two entries queued.
        u_busy = 1'b1;
        push(1'b1, 12'h200, 2'd1);
        push(1'b1, 12'h201, 2'd2);
        check("pp_count_before", 32'(dut.u_fifo.count_q), 2);
        u_busy = 1'b0;
        wait_en();
        check("pp_first_addr", 32'(u_addr), 32'h200);
        req_valid = 1'b1;
        req_cmd   = 1'b1;
        req_addr  = 12'h202;
        req_wdata = 2'd3;
        u_cmd_ack = 1'b1;
        u_busy    = 1'b1;
        @(negedge u_clk);
        req_valid = 1'b0;
        u_cmd_ack = 1'b0;
        check("pp_count_after", 32'(dut.u_fifo.count_q), 2);
        @(negedge u_clk);
        u_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge u_clk);
            if (!u_en) break;
        end
        serve(1'b1, 12'h201, 2'd2, 2'd0);
        serve(1'b1, 12'h202, 2'd3, 2'd0);
        check("pp_idle", 32'(idle), 1);

        // Reset while waiting for read data: response must be dropped.
        push(1'b0, 12'h7FF, 2'd0);
        wait_en();
        u_cmd_ack = 1'b1;
        @(negedge u_clk);
        u_cmd_ack = 1'b0;
        check("rst_in_wait_data", 32'(u_en), 1);
        #2;
        u_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        u_data_o     = 2'd3;
        u_data_valid = 1'b1;
        @(negedge u_clk);
        u_rst_n = 1'b1;
        @(negedge u_clk);
        u_data_valid = 1'b0;
        u_data_o     = '0;
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_resp", 32'(resp_valid), 0);
            check("midrst_no_en", 32'(u_en), 0);
            @(negedge u_clk);
        end
        check("midrst_idle", 32'(idle), 1);

`ifdef DRAM_USER_MASTER_TIMEOUT_EN
        // Controller never acknowledges: watchdog fires after 64 cycles in ISSUE.
        push(1'b0, 12'h010, 2'd0);
        wait_en();
        cycles = 0;
        for (int i = 0; i < 100 && u_en; i++) begin
            cycles++;
            @(negedge u_clk);
        end
        check("to_cycles", 32'(cycles), 64);
        check("to_err", 32'(err_timeout), 1);
        check("to_idle", 32'(idle), 1);
        check("to_no_resp", 32'(resp_valid), 0);
        push(1'b1, 12'h011, 2'd1);
        serve(1'b1, 12'h011, 2'd1, 2'd0);
        check("to_sticky", 32'(err_timeout), 1);
`else
        cycles = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
